// File: rtl/sr_grant_arbiter.sv
// Set/reset-style grant arbiter: a rotating-priority pick, then an ownership
// that is held while its request stays high, with a hold-timeout revoke.
module sr_grant_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 revoked
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(HOLD_MAX + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] ptr;
    logic [HW-1:0] hcnt;

    logic          pick_valid;
    logic [IW-1:0] pick;
    logic [IW-1:0] pick_next;
    logic          owner_req;
    logic          others;
    logic          hold_full;

    // Walk downward so the lowest offset from ptr is the last (winning) write.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                pick_valid = 1'b1;
                pick       = IW'(idx);
            end
        end
    end

    assign pick_next = (int'(pick) == N - 1) ? '0 : pick + 1'b1;
    assign owner_req = req[gnt_id];
    assign others    = |(req & ~gnt);
    assign hold_full = (hcnt == HW'(HOLD_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            revoked <= 1'b0;
            ptr     <= '0;
            hcnt    <= '0;
        end else begin
            revoked <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state  <= OWNED;
                        gnt    <= N'(1) << pick;
                        gnt_id <= pick;
                        busy   <= 1'b1;
                        hcnt   <= HW'(1);
                        ptr    <= pick_next;
                    end
                end
                OWNED: begin
                    // Release outranks the timeout, so no revoke on release.
                    if (!owner_req) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        gnt_id <= '0;
                        busy   <= 1'b0;
                        hcnt   <= '0;
                    end else if (hold_full && others) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        busy    <= 1'b0;
                        hcnt    <= '0;
                        revoked <= 1'b1;
                    end else if (!hold_full) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_grant_arbiter.sv
// Directed bench for sr_grant_arbiter (N=4, HOLD_MAX=8): vector table
// plus hand-written hold/no-revoke and non-owner-noise sequences.
module tb_sr_grant_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       revoked;

    int errors = 0;
    int checks = 0;

    sr_grant_arbiter #(.N(4), .HOLD_MAX(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .revoked (revoked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       rev;
        logic [1:0] ptr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic [3:0] q, logic [3:0] g,
                                logic [1:0] i, logic b, logic v,
                                logic [1:0] p);
        vec_t e;
        e.rst = r; e.req = q; e.gnt = g; e.id = i;
        e.busy = b; e.rev = v; e.ptr = p;
        tbl.push_back(e);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(logic r, logic [3:0] q);
        reset = r;
        req   = q;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, logic [3:0] g, logic [1:0] i,
                           logic b, logic v, logic [1:0] p);
        chk({tag, ".gnt"},     int'(gnt),     int'(g));
        chk({tag, ".gnt_id"},  int'(gnt_id),  int'(i));
        chk({tag, ".busy"},    int'(busy),    int'(b));
        chk({tag, ".revoked"}, int'(revoked), int'(v));
        chk({tag, ".ptr"},     int'(dut.ptr), int'(p));
    endtask

    initial begin
        // reset
        add(1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // first grant from index 0 upward
        add(0, 4'b1010, 4'b0010, 1, 1, 0, 2);
        // owner 1 releases, 3 still waiting
        add(0, 4'b1000, 4'b0000, 0, 0, 0, 2);
        add(0, 4'b1000, 4'b1000, 3, 1, 0, 0);
        // reset mid-ownership, then all requesting
        add(1, 4'b1000, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b1111, 4'b0001, 0, 1, 0, 1);
        // owner 0 holds with 1 pending: 8 cycles total, then revoke
        for (int k = 0; k < 7; k++)
            add(0, 4'b0011, 4'b0001, 0, 1, 0, 1);
        add(0, 4'b0011, 4'b0000, 0, 0, 1, 1);
        add(0, 4'b0011, 4'b0010, 1, 1, 0, 2);
        // owner 1 reaches hold limit, drops on that edge: release wins
        for (int k = 0; k < 7; k++)
            add(0, 4'b0011, 4'b0010, 1, 1, 0, 2);
        add(0, 4'b0001, 4'b0000, 0, 0, 0, 2);
        add(0, 4'b0001, 4'b0001, 0, 1, 0, 1);
        // release then stay idle
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 1);

        foreach (tbl[n]) begin
            step(tbl[n].rst, tbl[n].req);
            chk_all($sformatf("vec%0d", n), tbl[n].gnt, tbl[n].id,
                    tbl[n].busy, tbl[n].rev, tbl[n].ptr);
        end

        // single requester 2 held 20 cycles: never revoked
        for (int k = 0; k < 20; k++) begin
            step(0, 4'b0100);
            chk($sformatf("solo%0d.gnt", k), int'(gnt), 4'b0100);
            chk($sformatf("solo%0d.rev", k), int'(revoked), 0);
        end
        chk("solo.ptr", int'(dut.ptr), 3);

        // non-owner requests toggling during ownership have no effect
        step(0, 4'b0000);
        chk("gap.gnt", int'(gnt), 0);
        step(0, 4'b0010);
        chk_all("own1", 4'b0010, 1, 1, 0, 2);
        step(0, 4'b0011);
        chk("noise0.gnt", int'(gnt), 4'b0010);
        step(0, 4'b1010);
        chk("noise1.gnt", int'(gnt), 4'b0010);
        step(0, 4'b0110);
        chk_all("noise2", 4'b0010, 1, 1, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_grant_arbiter.md
SR_GRANT_ARBITER -- requirements
Module: sr_grant_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (legal range 2..16).
REQ-002 The block SHALL have parameter HOLD_MAX, default 8, giving the maximum cycles a grant is held while others wait (legal range 2..255).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset that overrides all other inputs.
REQ-005 The block SHALL have port req, input, N bits: req[i] high means requester i wants, or keeps, the resource.
REQ-006 The block SHALL have port gnt, output, N bits: registered, one-hot or all-zero grant vector.
REQ-007 The block SHALL have port gnt_id, output, clog2(N) bits: registered index of the current owner, 0 when idle.
REQ-008 The block SHALL have port busy, output, 1 bit: registered, high while any gnt bit is set.
REQ-009 The block SHALL have port revoked, output, 1 bit: registered, single-cycle pulse when a grant is forcibly removed by timeout.

Function
REQ-010 The block SHALL implement two states: IDLE (no grant) and OWNED (exactly one gnt bit set).
REQ-011 In IDLE with req != 0 at an edge, the block SHALL enter OWNED with gnt set for the first requester found searching from pointer ptr upward, modulo N; grant latency is 1 cycle.
REQ-012 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-013 On every new grant to index i, ptr SHALL become (i+1) mod N, so i wraps to 0 when i = N-1.
REQ-014 In OWNED, the grant SHALL be SR-like: it is set by arbitration and held while req[owner] = 1, independent of other req bits.
REQ-015 In OWNED with req[owner] = 0 at an edge (release), the block SHALL clear gnt and enter IDLE; at least one all-zero gnt cycle occurs between owners.
REQ-016 Hold counter hcnt (width clog2(HOLD_MAX+1)) SHALL load 1 on grant, increment each OWNED cycle, and saturate at HOLD_MAX.
REQ-017 In OWNED with hcnt == HOLD_MAX, req[owner] = 1 and any other req bit set, the block SHALL clear gnt, enter IDLE, and assert revoked for exactly the next cycle.
REQ-018 With hcnt == HOLD_MAX and no other requester, the owner SHALL keep the grant indefinitely with no revoke.
REQ-019 If release and the timeout condition coincide, release SHALL take precedence and revoked SHALL stay 0.
REQ-020 A revoked owner still holding req SHALL compete normally in the next IDLE arbitration; ptr already excludes it from first priority.
REQ-021 The block SHALL satisfy $onehot0(gnt) at all times, busy == |gnt, and gnt_id == index of the set gnt bit when busy.
REQ-022 Requests arriving or dropping in non-owner positions during OWNED SHALL have no effect on gnt.

Reset
REQ-023 While reset = 1 at an edge, the next state SHALL be: state IDLE, gnt = 0, gnt_id = 0, busy = 0, revoked = 0, ptr = 0, hcnt = 0.
REQ-024 Reset asserted mid-ownership SHALL drop the grant on that edge without a revoked pulse.
REQ-025 The first arbitration after reset SHALL start its search from index 0.

Verification (N=4, HOLD_MAX=8)
REQ-026 The bench SHALL check: reset, then req=4'b1010 -> after 1 edge gnt=4'b0010, gnt_id=1, busy=1, ptr=2.
REQ-027 The bench SHALL check: owner 1 drops req[1] with req[3] held -> gnt=0 for one cycle, then gnt=4'b1000, ptr wraps to 0.
REQ-028 The bench SHALL check: req=4'b0011 held continuously, no release -> owner 0 holds 8 cycles, revoked pulses once, one idle cycle, gnt=4'b0010.
REQ-029 The bench SHALL check: single requester 2 held 20 cycles -> gnt=4'b0100 throughout, revoked never set.
REQ-030 The bench SHALL check: req[owner] drops on the same edge hcnt reaches 8 with others pending -> gnt=0, revoked=0.
REQ-031 The bench SHALL check: reset pulsed while gnt=4'b1000 -> next cycle all outputs 0; then req=4'b1111 -> gnt=4'b0001.
